mux_rr_reg: RTL

- Registered N-input, W-bit multiplexer that arbitrates between channels itself, replacing the externally driven one-hot select of the combinational mux.
- Each input is a valid/ready channel. A round-robin arbiter picks one requester, the winner's payload is AND-OR selected and captured in an output register, and the result is presented downstream on a valid/ready interface.
- Used in common/ wherever several producers share one consumer: request funnels, writeback merge, debug taps.

---
 rtl/mux_rr_reg.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/mux_rr_reg.sv
// Registered N-input round-robin multiplexer with valid/ready channels on both sides.
// Optional macro MUX_RR_REG_SKID_EN adds a one-entry skid register behind the output.
module mux_rr_reg #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 32
) (
  input  logic                clk,
  input  logic                arst,
  input  logic [N-1:0]        i_x_vld,
  input  logic [N-1:0][W-1:0] i_x,
  output logic [N-1:0]        o_x_rdy,
  output logic                o_y_vld,
  output logic [W-1:0]        o_y,
  output logic [N-1:0]        o_y_sel,
  input  logic                i_y_rdy
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned SW = PW + 1;

  logic [PW-1:0] ptr;
  logic [N-1:0]  gnt_c;
  logic [PW-1:0] gnt_idx_c;
  logic [PW-1:0] ptr_nxt_c;
  logic [W-1:0]  data_c;
  logic          space_c;
  logic          accept_c;

  // Round-robin grant: scan channels starting at ptr, wrapping modulo N.
  always_comb begin
    logic          found;
    logic [SW-1:0] pos;
    logic [PW-1:0] idx;
    gnt_c = '0;
    found = 1'b0;
    pos   = '0;
    idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = {1'b0, ptr} + SW'(k);
      if (pos >= SW'(N)) begin
        pos = pos - SW'(N);
      end
      idx = PW'(pos);
      if (!found && i_x_vld[idx]) begin
        gnt_c[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  // Winner index and AND-OR payload select; unselected lanes contribute zero.
  always_comb begin
    gnt_idx_c = '0;
    data_c    = '0;
    for (int unsigned j = 0; j < N; j++) begin
      if (gnt_c[j]) begin
        gnt_idx_c = gnt_idx_c | PW'(j);
      end
      data_c = data_c | (i_x[j] & {W{gnt_c[j]}});
    end
  end

  always_comb begin
    if (gnt_idx_c == PW'(N - 1)) begin
      ptr_nxt_c = '0;
    end else begin
      ptr_nxt_c = gnt_idx_c + PW'(1);
    end
  end

  assign o_x_rdy  = gnt_c & {N{space_c}};
  assign accept_c = |o_x_rdy;

`ifdef MUX_RR_REG_SKID_EN

  logic          skid_vld;
  logic [W-1:0]  skid_data;
  logic [N-1:0]  skid_sel;
  logic          out_free_c;

  // Space comes only from registered state, cutting the i_y_rdy -> o_x_rdy path.
  assign space_c    = !skid_vld;
  assign out_free_c = !o_y_vld || i_y_rdy;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      ptr       <= '0;
      o_y_vld   <= 1'b0;
      o_y       <= '0;
      o_y_sel   <= '0;
      skid_vld  <= 1'b0;
      skid_data <= '0;
      skid_sel  <= '0;
    end else begin
      if (accept_c) begin
        ptr <= ptr_nxt_c;
      end
      if (out_free_c) begin
        // Skid contents always go out before any newer word.
        if (skid_vld) begin
          o_y      <= skid_data;
          o_y_sel  <= skid_sel;
          o_y_vld  <= 1'b1;
          skid_vld <= 1'b0;
        end else if (accept_c) begin
          o_y     <= data_c;
          o_y_sel <= gnt_c;
          o_y_vld <= 1'b1;
        end else begin
          o_y_vld <= 1'b0;
          o_y_sel <= '0;
        end
      end else if (accept_c) begin
        skid_data <= data_c;
        skid_sel  <= gnt_c;
        skid_vld  <= 1'b1;
      end
    end
  end

`else

  assign space_c = !o_y_vld || i_y_rdy;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      ptr     <= '0;
      o_y_vld <= 1'b0;
      o_y     <= '0;
      o_y_sel <= '0;
    end else begin
      if (accept_c) begin
        ptr     <= ptr_nxt_c;
        o_y     <= data_c;
        o_y_sel <= gnt_c;
        o_y_vld <= 1'b1;
      end else if (o_y_vld && i_y_rdy) begin
        o_y_vld <= 1'b0;
        o_y_sel <= '0;
      end
    end
  end

`endif

endmodule
